vector_floating_point_element_sequencer: RTL

- Sequences one vector floating-point instruction over a vector register group in 64-bit chunks.
- Per chunk: reads vs2/vs1 from the vector register file, drives the downstream combinational vector FP unit (sign injection unit, vs2/vs1/vd interface), registers the result and writes it back with a tail byte mask.
- Sits between the issue stage and the vector FP functional units; one instruction in flight.

---
 rtl/vector_floating_point_element_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/vector_floating_point_element_sequencer.sv
// Vector FP element sequencer: walks one instruction over a register group in
// 64-bit chunks through a read / execute / write pipeline with tail byte masks.
package vector_fp_pkg;
    localparam logic [1:0] BIT_MODE_32 = 2'd1;
    localparam logic [1:0] BIT_MODE_64 = 2'd2;

    localparam logic [1:0] SGNJ_VS1 = 2'd0;
    localparam logic [1:0] SGNJ_NEG = 2'd1;
    localparam logic [1:0] SGNJ_XOR = 2'd2;

    typedef struct packed {
        logic [1:0] bit_mode;
        logic [1:0] sign_injection_mode;
    } execution_vector_t;
endpackage

module vector_floating_point_element_sequencer
    import vector_fp_pkg::*;
#(
    parameter int VLEN = 512,
    localparam int CHUNKS = VLEN / 64,
    localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1,
    localparam int VL_W = $clog2(VLEN / 32) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              request_valid,
    output logic              request_ready,
    input  execution_vector_t request_execution_vector,
    input  logic [VL_W-1:0]   request_vl,
    input  logic [4:0]        request_vs2_register,
    input  logic [4:0]        request_vs1_register,
    input  logic [4:0]        request_vd_register,
    output logic              read_enable,
    output logic [4:0]        read_vs2_register,
    output logic [4:0]        read_vs1_register,
    output logic [IDX_W-1:0]  read_index,
    input  logic [63:0]       read_vs2_data,
    input  logic [63:0]       read_vs1_data,
    output execution_vector_t fu_execution_vector,
    output logic [63:0]       fu_vs2,
    output logic [63:0]       fu_vs1,
    input  logic [63:0]       fu_vd,
    output logic              write_enable,
    output logic [4:0]        write_register,
    output logic [IDX_W-1:0]  write_index,
    output logic [63:0]       write_data,
    output logic [7:0]        write_byte_enable,
    output logic              done,
    output logic              error
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t            state, state_next;
    execution_vector_t ctrl_q;
    logic [4:0]        vs2_q, vs1_q, vd_q;
    logic [IDX_W-1:0]  last_idx_q, rd_idx_q, ex_idx_q, wr_idx_q;
    logic              half_tail_q, ex_valid_q, ex_last_q, wr_valid_q, wr_last_q;
    logic [63:0]       op_vs2_q, op_vs1_q, wr_data_q;
    logic [7:0]        wr_mask_q;
    logic              done_q, error_q;

    logic              is32, mode_ok, accept, start;
    logic [VL_W-1:0]   vl_max, vl_clamp, chunks_n;

    // In 32-bit mode two elements share a chunk, so the count rounds up.
    always_comb begin
        is32     = (request_execution_vector.bit_mode == BIT_MODE_32);
        mode_ok  = is32 || (request_execution_vector.bit_mode == BIT_MODE_64);
        vl_max   = is32 ? VL_W'(2 * CHUNKS) : VL_W'(CHUNKS);
        vl_clamp = (request_vl > vl_max) ? vl_max : request_vl;
        chunks_n = is32 ? ((vl_clamp >> 1) + {{(VL_W-1){1'b0}}, vl_clamp[0]}) : vl_clamp;
        accept   = request_valid && (state == IDLE);
        start    = accept && mode_ok && (chunks_n != '0);
    end

    always_comb begin
        state_next    = state;
        request_ready = 1'b0;
        read_enable   = 1'b0;
        case (state)
            IDLE: begin
                request_ready = 1'b1;
                if (start) state_next = ISSUE;
            end
            ISSUE: begin
                read_enable = 1'b1;
                if (rd_idx_q == last_idx_q) state_next = DRAIN;
            end
            DRAIN: begin
                if (wr_valid_q && wr_last_q) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            ctrl_q      <= '0;
            vs2_q       <= '0;
            vs1_q       <= '0;
            vd_q        <= '0;
            last_idx_q  <= '0;
            half_tail_q <= 1'b0;
            rd_idx_q    <= '0;
            ex_valid_q  <= 1'b0;
            ex_idx_q    <= '0;
            ex_last_q   <= 1'b0;
            op_vs2_q    <= '0;
            op_vs1_q    <= '0;
            wr_valid_q  <= 1'b0;
            wr_idx_q    <= '0;
            wr_data_q   <= '0;
            wr_mask_q   <= '0;
            wr_last_q   <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state   <= state_next;
            // Empty or illegal requests finish immediately without touching the register file.
            done_q  <= accept && !start;
            error_q <= accept && !mode_ok;
            if (accept) begin
                ctrl_q      <= request_execution_vector;
                vs2_q       <= request_vs2_register;
                vs1_q       <= request_vs1_register;
                vd_q        <= request_vd_register;
                last_idx_q  <= IDX_W'(chunks_n - VL_W'(1));
                half_tail_q <= is32 && vl_clamp[0];
                rd_idx_q    <= '0;
            end else if (state == ISSUE) begin
                rd_idx_q <= rd_idx_q + IDX_W'(1);
            end

            ex_valid_q <= read_enable;
            ex_idx_q   <= rd_idx_q;
            ex_last_q  <= (rd_idx_q == last_idx_q);

            wr_valid_q <= ex_valid_q;
            if (ex_valid_q) begin
                op_vs2_q  <= read_vs2_data;
                op_vs1_q  <= read_vs1_data;
                wr_idx_q  <= ex_idx_q;
                wr_data_q <= fu_vd;
                wr_last_q <= ex_last_q;
                wr_mask_q <= (ex_last_q && half_tail_q) ? 8'h0F : 8'hFF;
            end
        end
    end

    assign read_vs2_register   = vs2_q;
    assign read_vs1_register   = vs1_q;
    assign read_index          = rd_idx_q;
    assign fu_execution_vector = ctrl_q;
    assign fu_vs2              = ex_valid_q ? read_vs2_data : op_vs2_q;
    assign fu_vs1              = ex_valid_q ? read_vs1_data : op_vs1_q;
    assign write_enable        = wr_valid_q;
    assign write_register      = vd_q;
    assign write_index         = wr_idx_q;
    assign write_data          = wr_data_q;
    assign write_byte_enable   = wr_mask_q;
    assign done                = done_q || (wr_valid_q && wr_last_q);
    assign error               = error_q;

endmodule
